// File: rtl/reset_seq.sv
// Power-up reset sequencer: staged release of memory, peripheral and CPU resets plus CPU-only soft reset.
// Optional RESET_SEQ_LOCK_MONITOR_EN: PLL lock loss after WAIT_LOCK restarts the whole sequence.
module reset_seq #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned MEM_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset_in,
   input  logic pll_locked,
   input  logic mem_init_done,
   input  logic soft_reset_req,
   output logic mem_reset,
   output logic periph_reset,
   output logic cpu_reset,
   output logic sys_ready,
   output logic mem_timeout
);

   localparam int unsigned CNT_MAX   = (HOLD_CYCLES > MEM_TIMEOUT) ? HOLD_CYCLES : MEM_TIMEOUT;
   localparam int unsigned CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_MEM_REL,
      S_PERIPH_REL,
      S_CPU_REL,
      S_RUN,
      S_SOFT
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             set_timeout;
   logic             mem_reset_d, periph_reset_d, cpu_reset_d, sys_ready_d;

   // State, counter and registered outputs
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state        <= S_HOLD;
         cnt          <= '0;
         mem_reset    <= 1'b1;
         periph_reset <= 1'b1;
         cpu_reset    <= 1'b1;
         sys_ready    <= 1'b0;
         mem_timeout  <= 1'b0;
      end else begin
         state        <= next_state;
         cnt          <= cnt_next;
         mem_reset    <= mem_reset_d;
         periph_reset <= periph_reset_d;
         cpu_reset    <= cpu_reset_d;
         sys_ready    <= sys_ready_d;
         if (set_timeout) mem_timeout <= 1'b1;
      end
   end

   // Next state, counter and output decode of the next state
   always_comb begin
      next_state  = state;
      cnt_next    = cnt;
      set_timeout = 1'b0;

      case (state)
         S_HOLD:       if (cnt == HOLD_LAST) next_state = S_WAIT_LOCK;
         S_WAIT_LOCK:  if (pll_locked) next_state = S_MEM_REL;
         S_MEM_REL: begin
            if (mem_init_done) begin
               next_state = S_PERIPH_REL;
            end else if (cnt == MEM_LAST) begin
               next_state  = S_PERIPH_REL;
               set_timeout = 1'b1;
            end
         end
         S_PERIPH_REL: if (cnt == HOLD_LAST) next_state = S_CPU_REL;
         S_CPU_REL:    next_state = S_RUN;
         S_RUN:        if (soft_reset_req) next_state = S_SOFT;
         S_SOFT:       if (cnt == HOLD_LAST) next_state = S_CPU_REL;
         default:      next_state = S_HOLD;
      endcase

`ifdef RESET_SEQ_LOCK_MONITOR_EN
      // Lock loss overrides every other exit, including a soft reset request
      if (!pll_locked && (state inside {S_MEM_REL, S_PERIPH_REL, S_CPU_REL, S_RUN, S_SOFT})) begin
         next_state  = S_HOLD;
         set_timeout = 1'b0;
      end
`endif

      // Counter restarts on every entry; timed states exit before it can reach CNT_MAX
      if (next_state != state) begin
         cnt_next = '0;
      end else if (state inside {S_HOLD, S_MEM_REL, S_PERIPH_REL, S_SOFT}) begin
         cnt_next = cnt + CNT_W'(1);
      end

      mem_reset_d    = next_state inside {S_HOLD, S_WAIT_LOCK};
      periph_reset_d = next_state inside {S_HOLD, S_WAIT_LOCK, S_MEM_REL};
      cpu_reset_d    = next_state inside {S_HOLD, S_WAIT_LOCK, S_MEM_REL, S_PERIPH_REL, S_SOFT};
      sys_ready_d    = (next_state == S_RUN);
   end

endmodule
